dct1d_stream: RTL and testbench
===============================

# dct1d_stream

Parametrised streaming 8-point 1D DCT engine with orthonormal scaling, AXI-style valid/ready on both sides, ping-pong input banks and a per-block forward/inverse mode. It takes over from the fixed-width 1D DCT as the row/column engine of the 2D DCT/IDCT datapath. It sustains 8 samples per 8 cycles under full backpressure compliance and reports framing errors.

## Interface
- IN_W, 8: signed input sample width (forward: pixels; inverse: coefficients).
- OUT_W, 16: signed output width. Results saturate to this width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  engine can accept a sample.
- s_data  in  IN_W  signed sample.
- s_last  in  1  marks 8th sample of a block.
- s_inv  in  1  block mode, sampled with the block's first sample: 0 = forward DCT-II, 1 = inverse DCT-III.
- m_valid  out  1  output coefficient/sample valid.
- m_ready  in  1  downstream accepts.
- m_data  out  OUT_W  signed result.
- m_index  out  3  result index 0..7.
- m_last  out  1  high with m_index==7.
- err_frame  out  1  one-cycle pulse on a framing error.

## Operation
- Coefficient table is Q1.14: C1=16069, C2=15137, C3=13623, C4=11585, C5=9102, C6=6270, C7=3196.
- T[k][n] = C4 for k=0. For k>0, T[k][n] = ±Cm, with m and sign taken from cos((2n+1)kπ/16) reduced to 0..7·π/16.
- Forward: acc[k] = Σn x[n]·T[k][n]. Inverse: acc[n] = Σk X[k]·T[k][n] (transpose).
- Result = saturate_OUT_W((acc + 2^14) >>> 15). This is arithmetic shift, round-half-up, giving an orthonormal transform.
- acc width is IN_W+19 bits. There is no internal overflow.
- Input side uses two 8-entry banks, each in state FREE or FULL, plus a per-bank mode bit.
  - wr_sel points to the filling bank. Write counter wr_cnt runs 0..7.
  - s_ready = (bank[wr_sel] == FREE).
  - Transfer occurs when s_valid && s_ready. It writes bank[wr_sel][wr_cnt], and latches s_inv when wr_cnt==0.
- Block close happens when wr_cnt==7 or s_last==1. On close: bank becomes FULL, wr_sel toggles, wr_cnt resets to 0.
  - s_last with wr_cnt<7: pulse err_frame, zero the unwritten entries, close the block.
  - wr_cnt==7 without s_last: pulse err_frame, close the block.
- Compute side: rd_sel points to the bank being read. Issue counter rd_k runs 0..7.
  - Advance enable: en = !m_valid || m_ready.
  - When en and bank[rd_sel]==FULL: stage A registers 8 products for index rd_k, with valid, index and last tags.
  - On issuing rd_k==7: bank[rd_sel] becomes FREE, rd_sel toggles.
  - Stage B, on en: adder tree, rounding and saturation into m_data/m_index/m_last. m_valid is set to stage A's valid.
- Output is held stable while m_valid && !m_ready. Stage A and the issue counter also freeze.
- A bank freed and a bank filled in the same cycle are always different banks; both updates take effect.

## Timing
- Reset values: s_ready=1 (both banks FREE), m_valid=0, m_data=0, m_index=0, m_last=0, err_frame=0, wr_sel=rd_sel=0, counters 0.
- Reset mid-block discards all buffered and in-flight data. The first transfer after reset starts at index 0.
- Latency: 8th sample accepted on edge E0 → index 0 product registered on E1 → m_valid high after E2 with index 0.
- Indices then follow at one per cycle while m_ready=1.
- Throughput: back-to-back blocks stream continuously. s_ready stays 1 as long as m_ready=1.
- Stall behaviour:
  - m_ready=0 stalls the output and issue logic.
  - The input keeps filling the other bank.
  - s_ready drops once both banks are FULL.
- Accepted input stalls of up to one block are absorbed without loss.
- err_frame is asserted in the cycle after the closing transfer, for one cycle.

## Test plan
- Forward, all x=10, m_ready=1 → X0=28, X1..X7=0, m_last only on index 7, m_valid two edges after the 8th transfer.
- Forward impulse x0=100, rest 0 → X0=35, X1=49. Then inverse with X0=100, rest 0 → all eight outputs 35.
- Back-to-back 4 blocks with m_ready=1 → s_ready never drops; 32 outputs contiguous with indices cycling 0..7.
- Backpressure: m_ready toggled with a random 50% pattern → outputs bit-exact to a reference model, no drops or duplicates; m_data stable while stalled; s_ready=0 only when both banks FULL.
- Framing: s_last on 5th sample → err_frame pulse, block computed with x5..x7=0. Eight samples without s_last → err_frame pulse, output is normal.
- Saturation with OUT_W=8: forward all x=127 → X0=127 (unsaturated value 359). Reset asserted mid-block → m_valid=0 next cycle, the next full block is correct.

Source files
------------

// File: rtl/dct1d_stream.sv
// Streaming 8-point orthonormal DCT-II / DCT-III engine with valid/ready on both sides.
// Two input banks alternate between filling and computing; results leave through a two-stage pipeline.
module dct1d_stream #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  s_data,
    input  logic                    s_last,
    input  logic                    s_inv,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic [2:0]              m_index,
    output logic                    m_last,
    output logic                    err_frame
);
    localparam int CW = 16;
    localparam int PW = IN_W + CW;
    localparam int AW = IN_W + 19;
    localparam logic signed [AW-1:0] HALF = AW'(32'sd16384);
    localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] MINV = AW'(64'sd0 - (64'sd1 <<< (OUT_W - 1)));

    // Q1.14 basis value T[k][n]; the angle (2n+1)k is folded into the first quadrant
    function automatic logic signed [CW-1:0] coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]           a;
        logic [3:0]           m;
        logic                 neg;
        logic signed [CW-1:0] mag;
        a = ({2'b00, n} * 5'd2 + 5'd1) * {2'b00, k};
        if (k == 3'd0) begin
            m   = 4'd4;
            neg = 1'b0;
        end else begin
            case (a[4:3])
                2'b00:   begin m = a[3:0];             neg = 1'b0; end
                2'b01:   begin m = 4'(5'd16 - a);      neg = 1'b1; end
                2'b10:   begin m = {1'b0, a[2:0]};     neg = 1'b1; end
                2'b11:   begin m = 4'(5'd0 - a);       neg = 1'b0; end
                default: begin m = 4'd0;               neg = 1'b0; end
            endcase
        end
        case (m)
            4'd1:    mag = 16'sd16069;
            4'd2:    mag = 16'sd15137;
            4'd3:    mag = 16'sd13623;
            4'd4:    mag = 16'sd11585;
            4'd5:    mag = 16'sd9102;
            4'd6:    mag = 16'sd6270;
            4'd7:    mag = 16'sd3196;
            default: mag = 16'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    logic signed [IN_W-1:0] bank_r [2][8];
    logic [1:0]             bank_full_r;
    logic [1:0]             mode_r;
    logic                   wr_sel_r;
    logic [2:0]             wr_cnt_r;
    logic                   rd_sel_r;
    logic [2:0]             rd_k_r;
    logic signed [PW-1:0]   prod_r [8];
    logic signed [PW-1:0]   prod_s [8];
    logic                   a_valid_r;
    logic [2:0]             a_idx_r;
    logic                   a_last_r;
    logic signed [PW-1:0]   x_s;
    logic signed [PW-1:0]   c_s;
    logic signed [AW-1:0]   sum_s;
    logic signed [AW-1:0]   rnd_s;
    logic signed [OUT_W-1:0] sat_s;
    logic                   en_s;
    logic                   xfer_s;
    logic                   close_s;
    logic                   frame_err_s;
    logic                   issue_s;
    logic                   free_s;

    assign s_ready     = ~bank_full_r[wr_sel_r];
    assign xfer_s      = s_valid & s_ready;
    assign close_s     = xfer_s & ((wr_cnt_r == 3'd7) | s_last);
    assign frame_err_s = xfer_s & ((s_last & (wr_cnt_r != 3'd7)) | ((wr_cnt_r == 3'd7) & ~s_last));
    assign en_s        = ~m_valid | m_ready;
    assign issue_s     = en_s & bank_full_r[rd_sel_r];
    assign free_s      = issue_s & (rd_k_r == 3'd7);

    // Fill side: store samples, latch block mode, close blocks and flag framing errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel_r  <= 1'b0;
            wr_cnt_r  <= 3'd0;
            mode_r    <= 2'b00;
            err_frame <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    bank_r[b][i] <= '0;
                end
            end
        end else begin
            err_frame <= frame_err_s;
            if (xfer_s) begin
                // A short block clears its tail so stale samples never reach the transform
                for (int i = 0; i < 8; i++) begin
                    if (3'(i) == wr_cnt_r) begin
                        bank_r[wr_sel_r][i] <= s_data;
                    end else if (s_last && (3'(i) > wr_cnt_r)) begin
                        bank_r[wr_sel_r][i] <= '0;
                    end
                end
                if (wr_cnt_r == 3'd0) begin
                    mode_r[wr_sel_r] <= s_inv;
                end
                if (close_s) begin
                    wr_cnt_r <= 3'd0;
                    wr_sel_r <= ~wr_sel_r;
                end else begin
                    wr_cnt_r <= wr_cnt_r + 3'd1;
                end
            end
        end
    end

    // Bank occupancy: filled on block close, released once its last index is issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_full_r <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (close_s && (wr_sel_r == 1'(b))) begin
                    bank_full_r[b] <= 1'b1;
                end else if (free_s && (rd_sel_r == 1'(b))) begin
                    bank_full_r[b] <= 1'b0;
                end
            end
        end
    end

    // Products for the current index; inverse mode walks the basis transposed
    always_comb begin
        x_s = '0;
        c_s = '0;
        for (int i = 0; i < 8; i++) begin
            x_s = PW'(bank_r[rd_sel_r][i]);
            if (mode_r[rd_sel_r]) begin
                c_s = PW'(coef(3'(i), rd_k_r));
            end else begin
                c_s = PW'(coef(rd_k_r, 3'(i)));
            end
            prod_s[i] = x_s * c_s;
        end
    end

    // Stage A: register products with their tags and advance the issue counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_sel_r  <= 1'b0;
            rd_k_r    <= 3'd0;
            a_valid_r <= 1'b0;
            a_idx_r   <= 3'd0;
            a_last_r  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                prod_r[i] <= '0;
            end
        end else if (en_s) begin
            a_valid_r <= bank_full_r[rd_sel_r];
            if (bank_full_r[rd_sel_r]) begin
                for (int i = 0; i < 8; i++) begin
                    prod_r[i] <= prod_s[i];
                end
                a_idx_r  <= rd_k_r;
                a_last_r <= (rd_k_r == 3'd7);
                rd_k_r   <= rd_k_r + 3'd1;
                if (rd_k_r == 3'd7) begin
                    rd_sel_r <= ~rd_sel_r;
                end
            end
        end
    end

    // Adder tree, round-half-up by 2^15 and clamp to the output width
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < 8; i++) begin
            sum_s = sum_s + AW'(prod_r[i]);
        end
        rnd_s = (sum_s + HALF) >>> 15;
        if (rnd_s > MAXV) begin
            sat_s = MAXV[OUT_W-1:0];
        end else if (rnd_s < MINV) begin
            sat_s = MINV[OUT_W-1:0];
        end else begin
            sat_s = rnd_s[OUT_W-1:0];
        end
    end

    // Stage B: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= 3'd0;
            m_last  <= 1'b0;
        end else if (en_s) begin
            m_valid <= a_valid_r;
            if (a_valid_r) begin
                m_data  <= sat_s;
                m_index <= a_idx_r;
                m_last  <= a_last_r;
            end
        end
    end

endmodule

// File: tb/tb_dct1d_stream.sv
// Self-checking bench for dct1d_stream: directed spec vectors plus randomized blocks
// checked against a cosine-based reference transform.
module tb_dct1d_stream;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid, s_ready, s_last, s_inv;
    logic signed [7:0] s_data;
    logic              m_valid, m_ready, m_last, err_frame;
    logic signed [15:0] m_data;
    logic [2:0]        m_index;

    logic              s_valid8, s_ready8, s_last8, s_inv8;
    logic signed [7:0] s_data8;
    logic              m_valid8, m_ready8, m_last8, err_frame8;
    logic signed [7:0] m_data8;
    logic [2:0]        m_index8;

    always #5 clk = ~clk;

    dct1d_stream #(.IN_W(8), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_inv(s_inv),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
        .err_frame(err_frame)
    );

    dct1d_stream #(.IN_W(8), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_last(s_last8), .s_inv(s_inv8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .m_index(m_index8), .m_last(m_last8),
        .err_frame(err_frame8)
    );

    typedef struct { int data; int idx; } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   stim_data[$];
    bit   stim_last[$];
    bit   stim_inv[$];
    bit   stim_close[$];
    int   exp_err = 0;
    int   first_out_cyc;
    int   last_close_cyc;

    // Orthonormal DCT basis scaled by 2^14, straight from the cosine definition
    function automatic int tcoef(int k, int n);
        real c;
        if (k == 0) return 11585;
        c = 16384.0 * $cos(3.14159265358979 * real'((2 * n + 1) * k) / 16.0);
        if (c >= 0.0) return $rtoi(c + 0.5);
        return -$rtoi(0.5 - c);
    endfunction

    function automatic int ref_out(int v[8], bit inv, int idx, int outw);
        longint acc = 0;
        longint r;
        longint mx;
        for (int j = 0; j < 8; j++) begin
            if (inv) acc += longint'(v[j]) * tcoef(j, idx);
            else     acc += longint'(v[j]) * tcoef(idx, j);
        end
        r  = (acc + 16384) >>> 15;
        mx = (longint'(1) << (outw - 1)) - 1;
        if (r > mx) r = mx;
        if (r < -mx - 1) r = -mx - 1;
        return int'(r);
    endfunction

    task automatic push_samples(int v[8], int len, bit last, bit inv);
        for (int i = 0; i < len; i++) begin
            stim_data.push_back(v[i]);
            stim_last.push_back(last && (i == len - 1));
            stim_inv.push_back(inv);
            stim_close.push_back(i == len - 1);
        end
        if (len < 8 || !last) exp_err++;
    endtask

    task automatic push_expected(int e[8]);
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            x.data = e[i];
            x.idx  = i;
            exp_q.push_back(x);
        end
    endtask

    task automatic add_block(int v[8], int len, bit last, bit inv);
        int pv[8];
        int e[8];
        push_samples(v, len, last, inv);
        for (int i = 0; i < 8; i++) pv[i] = (i < len) ? v[i] : 0;
        for (int i = 0; i < 8; i++) e[i] = ref_out(pv, inv, i, 16);
        push_expected(e);
    endtask

    task automatic rand_vals(output int v[8]);
        for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(255)) - 128;
    endtask

    // Drives queued samples, consumes outputs with a random ready pattern and scores them
    task automatic run(input int ready_pct, input bit no_drop, input bit contig);
        int   cyc = 0;
        int   err_seen = 0;
        int   closed = 0;
        int   done = 0;
        bit   started = 1'b0;
        bit   prev_stall = 1'b0;
        logic signed [15:0] prev_data = '0;
        logic [2:0] prev_idx = '0;
        logic prev_last = 1'b0;
        exp_t x;
        first_out_cyc  = -1;
        last_close_cyc = -1;
        while ((stim_data.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
            @(posedge clk); #1;
            if (stim_data.size() > 0) begin
                s_valid = 1'b1;
                s_data  = 8'(stim_data[0]);
                s_last  = stim_last[0];
                s_inv   = stim_inv[0];
            end else begin
                s_valid = 1'b0;
            end
            m_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_data !== prev_data || m_index !== prev_idx || m_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b d=%0d i=%0d, required v=1 d=%0d i=%0d",
                             m_valid, m_data, m_index, prev_data, prev_idx);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            prev_last  = m_last;
            if (err_frame) err_seen++;
            if (s_valid && !s_ready) begin
                checks++;
                if (no_drop || (closed - done) < 2) begin
                    failures++;
                    $display("FAIL s_ready_drop: got s_ready=0 with %0d blocks pending, required 1",
                             closed - done);
                end
            end
            if (contig && started && exp_q.size() > 0) begin
                checks++;
                if (!m_valid) begin
                    failures++;
                    $display("FAIL contiguous: got m_valid=0 mid-stream, required 1");
                end
            end
            if (s_valid && s_ready) begin
                if (stim_close[0]) begin
                    closed++;
                    last_close_cyc = cyc;
                end
                void'(stim_data.pop_front());
                void'(stim_last.pop_front());
                void'(stim_inv.pop_front());
                void'(stim_close.pop_front());
            end
            if (m_valid && !started) begin
                started = 1'b1;
                first_out_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_output: got d=%0d i=%0d, required none", m_data, m_index);
                end else begin
                    x = exp_q.pop_front();
                    if (m_data !== 16'(x.data) || m_index !== 3'(x.idx) || m_last !== (x.idx == 7)) begin
                        failures++;
                        $display("FAIL output: got d=%0d i=%0d l=%0b, required d=%0d i=%0d l=%0b",
                                 m_data, m_index, m_last, x.data, x.idx, (x.idx == 7));
                    end
                end
                if (m_last) done++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (cyc >= 2000) begin
            failures++;
            $display("FAIL timeout: got %0d outputs outstanding, required 0", exp_q.size());
            exp_q.delete();
            stim_data.delete(); stim_last.delete(); stim_inv.delete(); stim_close.delete();
        end
        checks++;
        if (err_seen != exp_err) begin
            failures++;
            $display("FAIL err_frame_count: got %0d, required %0d", err_seen, exp_err);
        end
        exp_err = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_inv = 1'b0; m_ready = 1'b1;
        s_valid8 = 1'b0; s_data8 = '0; s_last8 = 1'b0; s_inv8 = 1'b0; m_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'sd0 || m_index !== 3'd0
            || m_last !== 1'b0 || err_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset: got rdy=%0b v=%0b d=%0d i=%0d l=%0b e=%0b, required 1 0 0 0 0 0",
                     s_ready, m_valid, m_data, m_index, m_last, err_frame);
        end
        checks++;
        if (s_ready8 !== 1'b1 || m_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL reset8: got rdy=%0b v=%0b, required 1 0", s_ready8, m_valid8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_forward_const();
        int v[8];
        int e[8];
        for (int i = 0; i < 8; i++) v[i] = 10;
        e = '{28, 0, 0, 0, 0, 0, 0, 0};
        push_samples(v, 8, 1'b1, 1'b0);
        push_expected(e);
        run(100, 1'b1, 1'b1);
        checks++;
        if (first_out_cyc - last_close_cyc != 3) begin
            failures++;
            $display("FAIL latency: got %0d edges, required 2", first_out_cyc - last_close_cyc - 1);
        end
    endtask

    task automatic test_impulse();
        int v[8];
        int e[8];
        v = '{100, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) e[i] = ref_out(v, 1'b0, i, 16);
        e[0] = 35;
        e[1] = 49;
        push_samples(v, 8, 1'b1, 1'b0);
        push_expected(e);
        for (int i = 0; i < 8; i++) e[i] = 35;
        push_samples(v, 8, 1'b1, 1'b1);
        push_expected(e);
        run(100, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int v[8];
        for (int b = 0; b < 4; b++) begin
            rand_vals(v);
            add_block(v, 8, 1'b1, 1'(b % 2));
        end
        run(100, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int v[8];
        for (int b = 0; b < 6; b++) begin
            rand_vals(v);
            add_block(v, 8, 1'b1, 1'($urandom_range(1)));
        end
        run(50, 1'b0, 1'b0);
    endtask

    task automatic test_framing();
        int v[8];
        rand_vals(v); add_block(v, 8, 1'b1, 1'b0);
        rand_vals(v); add_block(v, 8, 1'b1, 1'b1);
        rand_vals(v); add_block(v, 5, 1'b1, 1'b0);
        rand_vals(v); add_block(v, 8, 1'b0, 1'($urandom_range(1)));
        rand_vals(v); add_block(v, 3, 1'b1, 1'b1);
        run(70, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        int v[8];
        int got = 0;
        int cnt = 0;
        int cyc = 0;
        int e;
        for (int i = 0; i < 8; i++) v[i] = 127;
        while ((cnt < 8 || got < 8) && cyc < 60) begin
            @(posedge clk); #1;
            s_valid8 = (cnt < 8);
            s_data8  = 8'sd127;
            s_last8  = (cnt == 7);
            s_inv8   = 1'b0;
            @(negedge clk);
            if (s_valid8 && s_ready8) cnt++;
            if (m_valid8 && m_ready8) begin
                e = (got == 0) ? 127 : ref_out(v, 1'b0, got, 8);
                checks++;
                if (m_data8 !== 8'(e) || m_index8 !== 3'(got)) begin
                    failures++;
                    $display("FAIL saturation: got d=%0d i=%0d, required d=%0d i=%0d",
                             m_data8, m_index8, e, got);
                end
                got++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        s_valid8 = 1'b0;
        checks++;
        if (got < 8) begin
            failures++;
            $display("FAIL saturation_timeout: got %0d outputs, required 8", got);
        end
    endtask

    task automatic test_reset_mid_block();
        int cnt = 0;
        int cyc = 0;
        int v[8];
        m_ready = 1'b0;
        while (cnt < 11 && cyc < 100) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = 8'($urandom_range(255));
            s_last  = (cnt == 7);
            s_inv   = 1'b0;
            @(negedge clk);
            if (s_valid && s_ready) cnt++;
            cyc++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!m_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!m_valid || cnt < 11) begin
            failures++;
            $display("FAIL pre_reset_fill: got m_valid=%0b accepted=%0d, required 1 and 11", m_valid, cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_index !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset: got v=%0b rdy=%0b i=%0d, required 0 1 0", m_valid, s_ready, m_index);
        end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        rand_vals(v);
        add_block(v, 8, 1'b1, 1'b0);
        run(100, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_forward_const();
        test_impulse();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_saturation();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
